// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants and helpers for the sync generator
// and the character/RGB stage downstream of it.
package vga_timing_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Both sync pulses are active low for this mode.
  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  // True when lo <= v < lo+len.
  function automatic logic in_window(input logic [COORD_W-1:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock into a registered one-clock pixel enable pulse.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  // Wrap the divider and flag the cycle after it sat at its last count.
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d = (div_q == DIV_LAST);
  end

  // Divider and tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign p_tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered sync, blanking
// and frame-start outputs, all aligned with the published coordinates.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Counters are COORD_W bits wide; larger timings cannot be represented.
  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
    $fatal(1, "vga_sync_gen: H_TOTAL/V_TOTAL exceed counter range");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $fatal(1, "vga_sync_gen: CLK_DIV must be at least 2");
  end

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

  logic               tick;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic               frame_start_q, frame_start_d;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .p_tick(tick)
  );

  // Advance counters on a tick; decode from next-state so outputs line up with coordinates.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    hsync_d    = in_window(x_d, H_DISPLAY + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d    = in_window(y_d, V_DISPLAY + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d = (int'(x_d) < H_DISPLAY) && (int'(y_d) < V_DISPLAY);
  end

  // Counter and output registers; reset returns everything to the (0,0) state.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign p_tick      = tick;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-size horizontal timing with a
// shortened vertical timing (8 lines: 4 visible, 1 front, 2 sync, 1 back).
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       p_tick;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, hsync, vsync, frame_start;

  int n_checks = 0;
  int n_errors = 0;
  int ed = 0;

  logic prev_valid = 1'b0;
  logic prev_tick, prev_hs, prev_vs, prev_vo;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV  (2),
    .H_DISPLAY(640),
    .H_FRONT  (16),
    .H_SYNC   (96),
    .H_BACK   (48),
    .V_DISPLAY(4),
    .V_FRONT  (1),
    .V_SYNC   (2),
    .V_BACK   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants: counter ranges, outputs only move after a tick.
  task automatic mon();
    if (prev_valid && !reset) begin
      check("x_range", 32'(pixel_x <= 10'd799), 1);
      check("y_range", 32'(pixel_y <= 10'd7), 1);
      check("no_change_without_tick",
            32'(!(((hsync !== prev_hs) || (vsync !== prev_vs) || (video_on !== prev_vo)) && !prev_tick)), 1);
    end
    prev_tick  = p_tick;
    prev_hs    = hsync;
    prev_vs    = vsync;
    prev_vo    = video_on;
    prev_valid = 1'b1;
  endtask

  // Step to the falling edge following rising edge number e (counted from reset release).
  task automatic go(input int e);
    while (ed < e) begin
      @(negedge clk);
      ed++;
      mon();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"},  32'(pixel_x), 0);
    check({tag, "_y"},  32'(pixel_y), 0);
    check({tag, "_tick"}, 32'(p_tick), 0);
    check({tag, "_von"}, 32'(video_on), 1);
    check({tag, "_hs"}, 32'(hsync), 1);
    check({tag, "_vs"}, 32'(vsync), 1);
    check({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  task automatic check_restart(input string tag);
    go(1);
    check({tag, "_e1_tick"}, 32'(p_tick), 0);
    check({tag, "_e1_x"}, 32'(pixel_x), 0);
    go(2);
    check({tag, "_e2_tick"}, 32'(p_tick), 1);
    check({tag, "_e2_x"}, 32'(pixel_x), 0);
    check({tag, "_e2_hs"}, 32'(hsync), 1);
    go(3);
    check({tag, "_e3_tick"}, 32'(p_tick), 0);
    check({tag, "_e3_x"}, 32'(pixel_x), 1);
    go(4);
    check({tag, "_e4_tick"}, 32'(p_tick), 1);
    check({tag, "_e4_x"}, 32'(pixel_x), 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    ed = 0;

    check_restart("start");

    go(1280);
    check("von_x639", 32'(pixel_x), 639);
    check("von_hi",   32'(video_on), 1);
    go(1281);
    check("voff_x640", 32'(pixel_x), 640);
    check("voff_lo",   32'(video_on), 0);
    go(1312);
    check("hs_x655", 32'(pixel_x), 655);
    check("hs_hi655", 32'(hsync), 1);
    go(1313);
    check("hs_x656", 32'(pixel_x), 656);
    check("hs_lo656", 32'(hsync), 0);
    go(1504);
    check("hs_x751", 32'(pixel_x), 751);
    check("hs_lo751", 32'(hsync), 0);
    go(1505);
    check("hs_x752", 32'(pixel_x), 752);
    check("hs_hi752", 32'(hsync), 1);

    go(1600);
    check("wrap0_x799", 32'(pixel_x), 799);
    check("wrap0_y0",   32'(pixel_y), 0);
    go(1601);
    check("wrap0_x0",  32'(pixel_x), 0);
    check("wrap0_y1",  32'(pixel_y), 1);
    check("wrap0_hs",  32'(hsync), 1);
    check("wrap0_von", 32'(video_on), 1);
    go(3200);
    check("wrap1_x799", 32'(pixel_x), 799);
    check("wrap1_y1",   32'(pixel_y), 1);
    go(3201);
    check("wrap1_x0", 32'(pixel_x), 0);
    check("wrap1_y2", 32'(pixel_y), 2);

    go(6401);
    check("vblank_y4",  32'(pixel_y), 4);
    check("vblank_von", 32'(video_on), 0);
    go(8000);
    check("vs_y4",  32'(pixel_y), 4);
    check("vs_hi4", 32'(vsync), 1);
    go(8001);
    check("vs_y5",  32'(pixel_y), 5);
    check("vs_lo5", 32'(vsync), 0);
    go(11200);
    check("vs_y6",  32'(pixel_y), 6);
    check("vs_lo6", 32'(vsync), 0);
    go(11201);
    check("vs_y7",  32'(pixel_y), 7);
    check("vs_hi7", 32'(vsync), 1);

    go(12800);
    check("fw_x799", 32'(pixel_x), 799);
    check("fw_y7",   32'(pixel_y), 7);
    check("fw_fs_pre", 32'(frame_start), 0);
    go(12801);
    check("fw_x0",  32'(pixel_x), 0);
    check("fw_y0",  32'(pixel_y), 0);
    check("fw_fs",  32'(frame_start), 1);
    check("fw_von", 32'(video_on), 1);
    check("fw_vs",  32'(vsync), 1);
    go(12802);
    check("fw_fs_post", 32'(frame_start), 0);
    go(25600);
    check("fw2_fs_pre", 32'(frame_start), 0);
    go(25601);
    check("fw2_fs", 32'(frame_start), 1);
    check("fw2_x0", 32'(pixel_x), 0);
    check("fw2_y0", 32'(pixel_y), 0);
    go(25602);
    check("fw2_fs_post", 32'(frame_start), 0);

    go(35001);
    check("mid_x700", 32'(pixel_x), 700);
    check("mid_y5",   32'(pixel_y), 5);
    check("mid_hs",   32'(hsync), 0);
    check("mid_vs",   32'(vsync), 0);
    check("mid_von",  32'(video_on), 0);
    reset = 1'b1;
    go(35002);
    check_reset_state("midrst");
    reset = 1'b0;
    ed = 0;
    check_restart("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
